// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes and
// the datapath mux/ALU select codes.
package mc_pkg;

    typedef logic [3:0] state_t;

    localparam state_t S_FETCH    = 4'd0;
    localparam state_t S_DECODE   = 4'd1;
    localparam state_t S_MEMADR   = 4'd2;
    localparam state_t S_LBRD     = 4'd3;
    localparam state_t S_LBWR     = 4'd4;
    localparam state_t S_SBWR     = 4'd5;
    localparam state_t S_RTYPEEX  = 4'd6;
    localparam state_t S_RTYPEWR  = 4'd7;
    localparam state_t S_BRANCHEX = 4'd8;
    localparam state_t S_ADDIEX   = 4'd9;
    localparam state_t S_ADDIWR   = 4'd10;
    localparam state_t S_JEX      = 4'd11;

    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [1:0] {
        SRCB_B     = 2'b00,
        SRCB_ONE   = 2'b01,
        SRCB_IMM   = 2'b10,
        SRCB_BRIMM = 2'b11
    } alusrcb_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_e;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10
    } pcsrc_e;

endpackage

// File: rtl/mc_beat_counter.sv
// Fetch beat counter: counts accepted instruction bytes 0..INSTR_BYTES-1 and
// flags the final beat so the FSM knows when the IR is complete.
module mc_beat_counter #(
    parameter int INSTR_BYTES = 4,
    parameter int BEAT_W      = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en_i,
    output logic [BEAT_W-1:0] beat_o,
    output logic              last_o
);

    logic [BEAT_W-1:0] beat_q;
    logic [BEAT_W-1:0] beat_d;

    assign last_o = (beat_q == BEAT_W'(INSTR_BYTES - 1));
    assign beat_o = beat_q;

    always_comb begin
        beat_d = beat_q;
        if (en_i) begin
            beat_d = last_o ? '0 : beat_q + BEAT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            beat_q <= '0;
        end else begin
            beat_q <= beat_d;
        end
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle control unit for the byte-serial datapath: multi-beat fetch,
// mem_ready stalls, sticky illegal-opcode flag and retired-instruction count.
module mc_controller
    import mc_pkg::*;
#(
    parameter int INSTR_BYTES = 4,
    parameter int RET_W       = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [5:0]             op,
    input  logic                   zero,
    input  logic                   mem_ready,
    output logic                   memread,
    output logic                   memwrite,
    output logic                   iord,
    output logic [INSTR_BYTES-1:0] irwrite,
    output logic                   alusrca,
    output logic [1:0]             alusrcb,
    output logic [1:0]             aluop,
    output logic [1:0]             pcsource,
    output logic                   pcen,
    output logic                   regwrite,
    output logic                   regdst,
    output logic                   memtoreg,
    output logic                   illegal,
    output logic [RET_W-1:0]       retired
);

    localparam int BEAT_W = (INSTR_BYTES > 1) ? $clog2(INSTR_BYTES) : 1;

    state_t            state_q, state_d;
    logic              illegal_q, illegal_d;
    logic [RET_W-1:0]  retired_q, retired_d;
    logic [BEAT_W-1:0] beat;
    logic              beat_last;
    logic              beat_en;
    logic              pcwrite;
    logic              pcwritecond;
    logic              branch_taken;
    logic              retire;

    mc_beat_counter #(
        .INSTR_BYTES(INSTR_BYTES),
        .BEAT_W     (BEAT_W)
    ) u_beat (
        .clk   (clk),
        .reset (reset),
        .en_i  (beat_en),
        .beat_o(beat),
        .last_o(beat_last)
    );

    // The IR still holds the branch, so op tells BEQ from BNE in BRANCHEX.
    assign branch_taken = (op == OP_BNE) ? !zero : zero;
    assign pcen         = pcwrite | (pcwritecond & branch_taken);
    assign illegal      = illegal_q;
    assign retired      = retired_q;

    always_comb begin
        state_d     = state_q;
        illegal_d   = illegal_q;
        beat_en     = 1'b0;
        retire      = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        iord        = 1'b0;
        irwrite     = '0;
        alusrca     = 1'b0;
        alusrcb     = SRCB_B;
        aluop       = ALUOP_ADD;
        pcsource    = PCSRC_ALU;
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        regwrite    = 1'b0;
        regdst      = 1'b0;
        memtoreg    = 1'b0;

        case (state_q)
            S_FETCH: begin
                memread = 1'b1;
                alusrcb = SRCB_ONE;
                if (mem_ready) begin
                    irwrite = INSTR_BYTES'(1) << beat;
                    pcwrite = 1'b1;
                    beat_en = 1'b1;
                    if (beat_last) begin
                        state_d = S_DECODE;
                    end
                end
            end
            S_DECODE: begin
                alusrcb = SRCB_BRIMM;
                case (op)
                    OP_LB, OP_SB:   state_d = S_MEMADR;
                    OP_RTYPE:       state_d = S_RTYPEEX;
                    OP_BEQ, OP_BNE: state_d = S_BRANCHEX;
                    OP_ADDI:        state_d = S_ADDIEX;
                    OP_J:           state_d = S_JEX;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                state_d = (op == OP_SB) ? S_SBWR : S_LBRD;
            end
            S_LBRD: begin
                memread = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    state_d = S_LBWR;
                end
            end
            S_LBWR: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_SBWR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
                state_d = S_RTYPEWR;
            end
            S_RTYPEWR: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCHEX: begin
                alusrca     = 1'b1;
                aluop       = ALUOP_SUB;
                pcwritecond = 1'b1;
                pcsource    = PCSRC_ALUOUT;
                retire      = 1'b1;
                state_d     = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                aluop   = ALUOP_ADD;
                state_d = S_ADDIWR;
            end
            S_ADDIWR: begin
                regwrite = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_JEX: begin
                pcwrite  = 1'b1;
                pcsource = PCSRC_JUMP;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        retired_d = retire ? retired_q + RET_W'(1) : retired_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: a 4-byte/16-bit instance and a
// 2-byte/4-bit instance share stimulus; each test checks one of them.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;

    logic       a_memread, a_memwrite, a_iord, a_alusrca, a_pcen;
    logic       a_regwrite, a_regdst, a_memtoreg, a_illegal;
    logic [3:0] a_irwrite;
    logic [1:0] a_alusrcb, a_aluop, a_pcsource;
    logic [15:0] a_retired;

    logic       b_memread, b_memwrite, b_iord, b_alusrca, b_pcen;
    logic       b_regwrite, b_regdst, b_memtoreg, b_illegal;
    logic [1:0] b_irwrite;
    logic [1:0] b_alusrcb, b_aluop, b_pcsource;
    logic [3:0] b_retired;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    mc_controller #(.INSTR_BYTES(4), .RET_W(16)) dut_a (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
        .memread(a_memread), .memwrite(a_memwrite), .iord(a_iord),
        .irwrite(a_irwrite), .alusrca(a_alusrca), .alusrcb(a_alusrcb),
        .aluop(a_aluop), .pcsource(a_pcsource), .pcen(a_pcen),
        .regwrite(a_regwrite), .regdst(a_regdst), .memtoreg(a_memtoreg),
        .illegal(a_illegal), .retired(a_retired)
    );

    mc_controller #(.INSTR_BYTES(2), .RET_W(4)) dut_b (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
        .memread(b_memread), .memwrite(b_memwrite), .iord(b_iord),
        .irwrite(b_irwrite), .alusrca(b_alusrca), .alusrcb(b_alusrcb),
        .aluop(b_aluop), .pcsource(b_pcsource), .pcen(b_pcen),
        .regwrite(b_regwrite), .regdst(b_regdst), .memtoreg(b_memtoreg),
        .illegal(b_illegal), .retired(b_retired)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Leaves both DUTs in FETCH beat 0 with reset released.
    task automatic do_reset();
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        op        = 6'b000000;
        zero      = 1'b0;
        mem_ready = 1'b0;

        // ---- reset state and LB with zero wait states (A, 4 beats)
        do_reset();
        chk("rst_memread", a_memread, 1);
        chk("rst_alusrcb", a_alusrcb, 2'b01);
        chk("rst_irwrite", a_irwrite, 0);
        chk("rst_pcen", a_pcen, 0);
        chk("rst_memwrite", a_memwrite, 0);
        chk("rst_regwrite", a_regwrite, 0);
        chk("rst_illegal", a_illegal, 0);
        chk("rst_retired", a_retired, 0);

        op = 6'b100000;
        mem_ready = 1'b1;
        #1;
        chk("lb_ir0", a_irwrite, 4'b0001);
        chk("lb_pcen0", a_pcen, 1);
        cyc(); chk("lb_ir1", a_irwrite, 4'b0010);
        cyc(); chk("lb_ir2", a_irwrite, 4'b0100);
        cyc(); chk("lb_ir3", a_irwrite, 4'b1000);
        cyc(); chk("lb_dec_srcb", a_alusrcb, 2'b11);
        chk("lb_dec_memread", a_memread, 0);
        cyc(); chk("lb_adr_srca", a_alusrca, 1);
        chk("lb_adr_srcb", a_alusrcb, 2'b10);
        cyc(); chk("lb_rd_memread", a_memread, 1);
        chk("lb_rd_iord", a_iord, 1);
        cyc(); chk("lb_wr_regwrite", a_regwrite, 1);
        chk("lb_wr_memtoreg", a_memtoreg, 1);
        chk("lb_wr_retired", a_retired, 0);
        cyc(); chk("lb_done_retired", a_retired, 1);
        chk("lb_done_fetch", a_memread, 1);

        // ---- fetch stall on beat 1 (B, 2 beats), then R-type
        do_reset();
        op = 6'b000000;
        mem_ready = 1'b1;
        #1;
        chk("st_ir0", b_irwrite, 2'b01);
        cyc();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("st_hold_ir", b_irwrite, 2'b00);
            chk("st_hold_pcen", b_pcen, 0);
            chk("st_hold_memread", b_memread, 1);
            cyc();
        end
        mem_ready = 1'b1;
        #1;
        chk("st_ir1", b_irwrite, 2'b10);
        chk("st_pcen1", b_pcen, 1);
        cyc(); chk("st_decode", b_alusrcb, 2'b11);
        chk("st_decode_memread", b_memread, 0);
        cyc(); chk("rt_ex_aluop", b_aluop, 2'b10);
        chk("rt_ex_srca", b_alusrca, 1);
        cyc(); chk("rt_wr_regdst", b_regdst, 1);
        chk("rt_wr_regwrite", b_regwrite, 1);
        cyc(); chk("rt_retired", b_retired, 1);

        // ---- BNE taken and not taken (A)
        do_reset();
        op = 6'b000101;
        mem_ready = 1'b1;
        zero = 1'b0;
        cyc(5);
        chk("bne_t_pcen", a_pcen, 1);
        chk("bne_t_pcsrc", a_pcsource, 2'b01);
        chk("bne_t_aluop", a_aluop, 2'b01);
        zero = 1'b1;
        #1;
        chk("bne_nt_pcen_same_cycle", a_pcen, 0);
        cyc();
        chk("bne_retired1", a_retired, 1);
        cyc(5);
        chk("bne_nt_pcen", a_pcen, 0);
        chk("bne_nt_pcsrc", a_pcsource, 2'b01);
        cyc();
        chk("bne_retired2", a_retired, 2);
        zero = 1'b0;

        // ---- illegal opcode, then J (A)
        do_reset();
        op = 6'b111111;
        cyc(4);
        chk("ill_decode_flag", a_illegal, 0);
        cyc();
        chk("ill_flag", a_illegal, 1);
        chk("ill_fetch", a_memread, 1);
        chk("ill_retired", a_retired, 0);
        op = 6'b000010;
        cyc(5);
        chk("j_pcen", a_pcen, 1);
        chk("j_pcsrc", a_pcsource, 2'b10);
        cyc();
        chk("j_retired", a_retired, 1);
        chk("ill_sticky", a_illegal, 1);

        // ---- reset during stalled SBWR (A)
        do_reset();
        op = 6'b101000;
        mem_ready = 1'b1;
        cyc(6);
        mem_ready = 1'b0;
        #1;
        chk("sb_memwrite", a_memwrite, 1);
        chk("sb_iord", a_iord, 1);
        cyc();
        chk("sb_stall_memwrite", a_memwrite, 1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        #1;
        chk("sbrst_memwrite", a_memwrite, 0);
        chk("sbrst_memread", a_memread, 1);
        chk("sbrst_retired", a_retired, 0);
        chk("sbrst_illegal", a_illegal, 0);
        mem_ready = 1'b1;
        #1;
        chk("sbrst_beat0", a_irwrite, 4'b0001);

        // ---- ADDI and retired wrap (B, RET_W=4)
        do_reset();
        op = 6'b001000;
        mem_ready = 1'b1;
        cyc(3);
        chk("addi_ex_srcb", b_alusrcb, 2'b10);
        chk("addi_ex_aluop", b_aluop, 2'b00);
        chk("addi_ex_srca", b_alusrca, 1);
        cyc();
        chk("addi_wr_regwrite", b_regwrite, 1);
        chk("addi_wr_regdst", b_regdst, 0);
        chk("addi_wr_memtoreg", b_memtoreg, 0);
        cyc();
        chk("addi_ret1", b_retired, 1);
        cyc(75);
        chk("addi_ret16_wrap", b_retired, 0);
        cyc(5);
        chk("addi_ret17", b_retired, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
# mc_controller

Parametrised multicycle control unit for the byte-serial processor datapath. It fetches an instruction over a configurable number of byte beats. It stalls on a memory ready handshake and adds ADDI and BNE to the LB/SB/R-type/BEQ/J set. It also flags illegal opcodes and counts retired instructions. It drives the same datapath control points as the current controller, and the existing ALU-control decoder consumes its `aluop` output unchanged.

## Interface
Parameters:
- INSTR_BYTES, 4, fetch beats per instruction (2..8); sets width of `irwrite`
- RET_W, 16, width of retired-instruction counter

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- op  in  6  opcode field from instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory accepted/completed current access this cycle
- memread, memwrite  out  1  memory strobes, held until `mem_ready`
- iord  out  1  address select: 0 = PC, 1 = ALU result
- irwrite  out  INSTR_BYTES  one-hot IR byte-lane enable
- alusrca  out  1  0 = PC, 1 = register A
- alusrcb  out  2  00 = B, 01 = constant 1, 10 = imm, 11 = imm shifted for branch
- aluop  out  2  00 = add, 01 = sub, 10 = funct
- pcsource  out  2  00 = ALU, 01 = ALUOut, 10 = jump target
- pcen  out  1  PC write enable
- regwrite, regdst, memtoreg  out  1  register-file controls
- illegal  out  1  sticky undefined-opcode flag
- retired  out  RET_W  count of completed instructions

## Operation
- Opcodes: LB 100000, SB 101000, RTYPE 000000, BEQ 000100, BNE 000101, ADDI 001000, J 000010.
- States: FETCH, DECODE, MEMADR, LBRD, LBWR, SBWR, RTYPEEX, RTYPEWR, BRANCHEX, ADDIEX, ADDIWR, JEX.
- FETCH:
  - Beat counter `beat` runs 0..INSTR_BYTES-1.
  - memread=1, alusrcb=01.
  - On `mem_ready`: irwrite = 1<<beat, pcwrite=1, beat advances.
  - After the last accepted beat, go to DECODE and clear `beat`.
  - Without `mem_ready`: irwrite=0, pcwrite=0, and state and beat hold.
- DECODE: alusrcb=11. Next state by opcode:
  - LB/SB → MEMADR
  - RTYPE → RTYPEEX
  - BEQ/BNE → BRANCHEX
  - ADDI → ADDIEX
  - J → JEX
  - Other → FETCH, and `illegal` sets.
- MEMADR: alusrca=1, alusrcb=10. Next LBRD for LB, SBWR for SB.
- LBRD: memread=1, iord=1. Go to LBWR on `mem_ready`, else hold.
- LBWR: regwrite=1, memtoreg=1.
- SBWR: memwrite=1, iord=1. Go to FETCH on `mem_ready`, else hold.
- RTYPEEX: alusrca=1, aluop=10. RTYPEWR: regdst=1, regwrite=1.
- BRANCHEX: alusrca=1, aluop=01, pcwritecond=1, pcsource=01. Taken when `zero` for BEQ, `!zero` for BNE.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00. ADDIWR: regwrite=1, regdst=0, memtoreg=0.
- JEX: pcwrite=1, pcsource=10.
- pcen = pcwrite | (pcwritecond & branch_taken).
- Every output not listed for a state is 0.
- Retirement:
  - `retired` increments by 1 on the last cycle of LBWR, SBWR (with `mem_ready`), RTYPEWR, BRANCHEX, ADDIWR and JEX.
  - Illegal opcodes do not retire.
  - The counter wraps modulo 2^RET_W.

## Timing
- Outputs are combinational from state/beat. `irwrite`, fetch `pcwrite` and `pcen` are additionally gated by `mem_ready`.
- Reset: state=FETCH, beat=0, illegal=0, retired=0. Immediately after reset memread=1, alusrcb=01, all other outputs 0.
- Reset mid-instruction, including a stalled access, aborts it. No write strobe is asserted in the cycle after reset.
- Zero-wait-state latency:
  - LB = INSTR_BYTES+4 cycles
  - SB = INSTR_BYTES+3
  - R-type and ADDI = INSTR_BYTES+3
  - BEQ/BNE and J = INSTR_BYTES+2
- Each cycle with `mem_ready`=0 in a memory state adds one cycle.
- `mem_ready` is ignored in non-memory states.
- `illegal` sets in the cycle after DECODE sees the bad opcode, and clears only on reset.

## Structure
- Package `mc_pkg`: state enum, opcode constants, alusrcb/pcsource/aluop encodings.
- Sub-module `mc_beat_counter`: beat count with enable and last-beat flag, parametrised by INSTR_BYTES.
- ALU-control decoding stays in its existing separate module.

## Test plan
- INSTR_BYTES=4, mem_ready=1, op=100000 → irwrite 0001, 0010, 0100, 1000 on consecutive cycles; regwrite=1, memtoreg=1 in cycle 8; retired 0→1.
- INSTR_BYTES=2, mem_ready low for 3 cycles during beat 1 → irwrite=10 held off, pcen=0 while stalled; DECODE reached 3 cycles later than with no stall.
- op=000101 (BNE): zero=0 → pcen=1 with pcsource=01 in BRANCHEX; zero=1 → pcen=0.
- op=111111 → FETCH after DECODE, illegal=1 thereafter, retired unchanged.
- Reset asserted during SBWR with mem_ready=0 → memwrite=0 next cycle, state FETCH beat 0, retired=0.
- RET_W=4: run 17 ADDI instructions → retired=1, showing wrap.
